// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU register responder and its OAM DMA engine.
package ppu_pkg;

  // CPU-visible PPU register selector.
  typedef enum logic [3:0] {
    REG_PPUCTRL   = 4'd0,
    REG_PPUMASK   = 4'd1,
    REG_PPUSTATUS = 4'd2,
    REG_OAMADDR   = 4'd3,
    REG_OAMDATA   = 4'd4,
    REG_PPUSCROLL = 4'd5,
    REG_PPUADDR   = 4'd6,
    REG_PPUDATA   = 4'd7,
    REG_OAMDMA    = 4'd8
  } reg_t;

  // OAM DMA sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  // PPUCTRL bit positions.
  localparam int CTRL_NMI_EN = 7;
  localparam int CTRL_INC32  = 2;

  // Number of bytes copied by one OAMDMA transfer.
  localparam int DMA_LEN = 256;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAMDMA copy engine: after a start strobe, waits one alignment step, then
// alternates CPU-bus reads and OAM writes for 256 bytes, one step per clock_en.
module ppu_oam_dma
  import ppu_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clock_en_i,
  input  logic        start_i,
  input  logic [7:0]  page_i,
  input  logic [7:0]  dma_rd_data_i,
  output logic        dma_active_o,
  output logic        dma_rd_en_o,
  output logic [15:0] dma_rd_addr_o,
  output logic        oam_we_o,
  output logic [7:0]  oam_wr_data_o
);

  dma_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] page_q, page_d;
  logic       active;

  // State, byte counter and source page registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      page_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
    end
  end

  // Next-state logic: each non-idle state advances only on a clock_en step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ALIGN;
          page_d  = page_i;
          cnt_d   = 8'd0;
        end
      end
      ALIGN: if (clock_en_i) state_d = READ;
      READ:  if (clock_en_i) state_d = WRITE;
      WRITE: begin
        if (clock_en_i) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q == 8'(DMA_LEN - 1)) ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The stall request drops in the very cycle reset is asserted.
  assign active        = (state_q != IDLE) & ~reset_i;
  assign dma_active_o  = active;
  assign dma_rd_en_o   = active & (state_q == READ) & clock_en_i;
  assign dma_rd_addr_o = {page_q, cnt_q};
  assign oam_we_o      = active & (state_q == WRITE) & clock_en_i;
  assign oam_wr_data_o = oam_we_o ? dma_rd_data_i : 8'd0;

endmodule

// File: rtl/ppu_register_responder.sv
// PPU side of the CPU register bus: control/scroll/VRAM-address state, the shared
// write toggle, the PPUDATA read buffer, status flags, NMI and the OAM port.
module ppu_register_responder
  import ppu_pkg::*;
#(
  parameter int VRAM_AW = 14,
  parameter int OAM_AW  = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clock_en_i,
  input  reg_t               reg_sel_i,
  input  logic               reg_en_i,
  input  logic               reg_rw_i,
  input  logic [7:0]         reg_data_wr_i,
  output logic [7:0]         reg_data_rd_o,
  input  logic               vblank_set_i,
  input  logic               vblank_clr_i,
  input  logic               sprite0_set_i,
  input  logic               ovf_set_i,
  output logic [7:0]         ppuctrl_o,
  output logic [7:0]         ppumask_o,
  output logic [7:0]         scroll_x_o,
  output logic [7:0]         scroll_y_o,
  output logic               nmi_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic               vram_we_o,
  output logic               vram_re_o,
  output logic [7:0]         vram_wr_data_o,
  input  logic [7:0]         vram_rd_data_i,
  output logic [OAM_AW-1:0]  oam_addr_o,
  output logic               oam_we_o,
  output logic [7:0]         oam_wr_data_o,
  input  logic [7:0]         oam_rd_data_i,
  output logic               dma_active_o,
  output logic [15:0]        dma_rd_addr_o,
  output logic               dma_rd_en_o,
  input  logic [7:0]         dma_rd_data_i
);

  logic [7:0]         ppuctrl_q, ppuctrl_d;
  logic [7:0]         ppumask_q, ppumask_d;
  logic [7:0]         scroll_x_q, scroll_x_d;
  logic [7:0]         scroll_y_q, scroll_y_d;
  logic [7:0]         io_latch_q, io_latch_d;
  logic [7:0]         rd_buffer_q, rd_buffer_d;
  logic [7:0]         reg_data_rd_q, reg_data_rd_d;
  logic               w_q, w_d;
  logic               vblank_q, vblank_d;
  logic               s0_q, s0_d;
  logic               ovf_q, ovf_d;
  logic               rd_pending_q, rd_pending_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [OAM_AW-1:0]  oam_addr_q, oam_addr_d;

  logic               access, cpu_wr, cpu_rd, status_rd;
  logic               cpu_vram_we, cpu_vram_re, cpu_oam_we;
  logic               dma_start, dma_active, dma_oam_we;
  logic [7:0]         dma_oam_data;
  logic [VRAM_AW-1:0] vram_step;
  logic [7:0]         rd_buffer_fwd;

  // A register access happens only on a CPU cycle while the DMA is not stalling the bus.
  assign access      = clock_en_i & reg_en_i & ~dma_active & ~reset_i;
  assign cpu_wr      = access & reg_rw_i;
  assign cpu_rd      = access & ~reg_rw_i;
  assign status_rd   = cpu_rd & (reg_sel_i == REG_PPUSTATUS);
  assign cpu_vram_we = cpu_wr & (reg_sel_i == REG_PPUDATA);
  assign cpu_vram_re = cpu_rd & (reg_sel_i == REG_PPUDATA);
  assign cpu_oam_we  = cpu_wr & (reg_sel_i == REG_OAMDATA);
  assign dma_start   = cpu_wr & (reg_sel_i == REG_OAMDMA);
  assign vram_step   = ppuctrl_q[CTRL_INC32] ? VRAM_AW'(32) : VRAM_AW'(1);

  // VRAM data lands one clock after the read strobe; forward it so a PPUDATA
  // read that arrives on that same clock already sees the refilled buffer.
  assign rd_buffer_fwd = rd_pending_q ? vram_rd_data_i : rd_buffer_q;

  ppu_oam_dma u_dma (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .clock_en_i    (clock_en_i),
    .start_i       (dma_start),
    .page_i        (reg_data_wr_i),
    .dma_rd_data_i (dma_rd_data_i),
    .dma_active_o  (dma_active),
    .dma_rd_en_o   (dma_rd_en_o),
    .dma_rd_addr_o (dma_rd_addr_o),
    .oam_we_o      (dma_oam_we),
    .oam_wr_data_o (dma_oam_data)
  );

  // Next-state logic for the register file, toggle, buffer, addresses and status flags.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
    ppuctrl_d     = ppuctrl_q;
    ppumask_d     = ppumask_q;
    scroll_x_d    = scroll_x_q;
    scroll_y_d    = scroll_y_q;
    io_latch_d    = io_latch_q;
    reg_data_rd_d = reg_data_rd_q;
    w_d           = w_q;
    vram_addr_d   = vram_addr_q;
    oam_addr_d    = oam_addr_q;
    rd_buffer_d   = rd_buffer_fwd;
    rd_pending_d  = cpu_vram_re;

    if (cpu_wr) begin
      io_latch_d = reg_data_wr_i;
      case (reg_sel_i)
        REG_PPUCTRL: ppuctrl_d = reg_data_wr_i;
        REG_PPUMASK: ppumask_d = reg_data_wr_i;
        REG_OAMADDR: oam_addr_d = reg_data_wr_i[OAM_AW-1:0];
        REG_OAMDATA: oam_addr_d = oam_addr_q + OAM_AW'(1);
        REG_PPUSCROLL: begin
          if (!w_q) scroll_x_d = reg_data_wr_i;
          else      scroll_y_d = reg_data_wr_i;
          w_d = ~w_q;
        end
        REG_PPUADDR: begin
          // High byte first; bits above the VRAM address width are dropped.
          if (!w_q) vram_addr_d[VRAM_AW-1:8] = reg_data_wr_i[VRAM_AW-9:0];
          else      vram_addr_d[7:0]         = reg_data_wr_i;
          w_d = ~w_q;
        end
        REG_PPUDATA: vram_addr_d = vram_addr_q + vram_step;
        default: ;
      endcase
    end else if (cpu_rd) begin
      case (reg_sel_i)
        REG_PPUSTATUS: begin
          reg_data_rd_d = {vblank_q, s0_q, ovf_q, io_latch_q[4:0]};
          w_d           = 1'b0;
        end
        REG_OAMDATA: reg_data_rd_d = oam_rd_data_i;
        REG_PPUDATA: begin
          reg_data_rd_d = rd_buffer_fwd;
          vram_addr_d   = vram_addr_q + vram_step;
        end
        default: reg_data_rd_d = io_latch_q;
      endcase
    end

    // DMA owns the OAM address while active; CPU accesses are blocked then.
    if (dma_oam_we) oam_addr_d = oam_addr_q + OAM_AW'(1);

    // A status read racing vblank_set wins, so that frame's NMI is lost.
    vblank_d = vblank_q;
    if (vblank_clr_i || status_rd) vblank_d = 1'b0;
    else if (vblank_set_i)         vblank_d = 1'b1;

    s0_d = vblank_clr_i ? 1'b0 : (sprite0_set_i | s0_q);
    ovf_d = vblank_clr_i ? 1'b0 : (ovf_set_i | ovf_q);
  end

  // State registers, all cleared by the synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ppuctrl_q     <= 8'd0;
      ppumask_q     <= 8'd0;
      scroll_x_q    <= 8'd0;
      scroll_y_q    <= 8'd0;
      io_latch_q    <= 8'd0;
      rd_buffer_q   <= 8'd0;
      reg_data_rd_q <= 8'd0;
      w_q           <= 1'b0;
      vblank_q      <= 1'b0;
      s0_q          <= 1'b0;
      ovf_q         <= 1'b0;
      rd_pending_q  <= 1'b0;
      vram_addr_q   <= '0;
      oam_addr_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register sees the pre-edge values of the others.
      ppuctrl_q     <= ppuctrl_d;
      ppumask_q     <= ppumask_d;
      scroll_x_q    <= scroll_x_d;
      scroll_y_q    <= scroll_y_d;
      io_latch_q    <= io_latch_d;
      rd_buffer_q   <= rd_buffer_d;
      reg_data_rd_q <= reg_data_rd_d;
      w_q           <= w_d;
      vblank_q      <= vblank_d;
      s0_q          <= s0_d;
      ovf_q         <= ovf_d;
      rd_pending_q  <= rd_pending_d;
      vram_addr_q   <= vram_addr_d;
      oam_addr_q    <= oam_addr_d;
    end
  end

  assign reg_data_rd_o  = reg_data_rd_q;
  assign ppuctrl_o      = ppuctrl_q;
  assign ppumask_o      = ppumask_q;
  assign scroll_x_o     = scroll_x_q;
  assign scroll_y_o     = scroll_y_q;
  assign nmi_o          = vblank_q & ppuctrl_q[CTRL_NMI_EN];
  assign vram_addr_o    = vram_addr_q;
  assign vram_we_o      = cpu_vram_we;
  assign vram_re_o      = cpu_vram_re;
  assign vram_wr_data_o = cpu_vram_we ? reg_data_wr_i : 8'd0;
  assign oam_addr_o     = oam_addr_q;
  assign oam_we_o       = cpu_oam_we | dma_oam_we;
  assign oam_wr_data_o  = dma_oam_we ? dma_oam_data : (cpu_oam_we ? reg_data_wr_i : 8'd0);
  assign dma_active_o   = dma_active;

endmodule

// File: tb/tb_ppu_register_responder.sv
// Scoreboard bench for ppu_register_responder: expected VRAM/OAM writes and
// register read data are queued as stimulus is driven and popped as the DUT responds.
module tb_ppu_register_responder;
  import ppu_pkg::*;

  localparam int VRAM_AW = 14;
  localparam int OAM_AW  = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               clock_en;
  reg_t               reg_sel;
  logic               reg_en, reg_rw;
  logic [7:0]         reg_data_wr, reg_data_rd;
  logic               vblank_set, vblank_clr, sprite0_set, ovf_set;
  logic [7:0]         ppuctrl, ppumask, scroll_x, scroll_y;
  logic               nmi;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_we, vram_re;
  logic [7:0]         vram_wr_data, vram_rd_data;
  logic [OAM_AW-1:0]  oam_addr;
  logic               oam_we;
  logic [7:0]         oam_wr_data, oam_rd_data;
  logic               dma_active, dma_rd_en;
  logic [15:0]        dma_rd_addr;
  logic [7:0]         dma_rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int oam_wr_seen = 0;

  logic [31:0] vram_exp_q[$];
  logic [31:0] oam_exp_q[$];
  logic [7:0]  rd_exp_q[$];

  logic [7:0] vram_mem [0:(1<<VRAM_AW)-1];
  logic [7:0] oam_mem  [0:(1<<OAM_AW)-1];

  always #5 clock = ~clock;

  ppu_register_responder #(.VRAM_AW(VRAM_AW), .OAM_AW(OAM_AW)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .clock_en_i     (clock_en),
    .reg_sel_i      (reg_sel),
    .reg_en_i       (reg_en),
    .reg_rw_i       (reg_rw),
    .reg_data_wr_i  (reg_data_wr),
    .reg_data_rd_o  (reg_data_rd),
    .vblank_set_i   (vblank_set),
    .vblank_clr_i   (vblank_clr),
    .sprite0_set_i  (sprite0_set),
    .ovf_set_i      (ovf_set),
    .ppuctrl_o      (ppuctrl),
    .ppumask_o      (ppumask),
    .scroll_x_o     (scroll_x),
    .scroll_y_o     (scroll_y),
    .nmi_o          (nmi),
    .vram_addr_o    (vram_addr),
    .vram_we_o      (vram_we),
    .vram_re_o      (vram_re),
    .vram_wr_data_o (vram_wr_data),
    .vram_rd_data_i (vram_rd_data),
    .oam_addr_o     (oam_addr),
    .oam_we_o       (oam_we),
    .oam_wr_data_o  (oam_wr_data),
    .oam_rd_data_i  (oam_rd_data),
    .dma_active_o   (dma_active),
    .dma_rd_addr_o  (dma_rd_addr),
    .dma_rd_en_o    (dma_rd_en),
    .dma_rd_data_i  (dma_rd_data)
  );

  // CPU-bus contents seen by the DMA: a fixed pattern that differs per page.
  function automatic logic [7:0] cpu_byte(input logic [15:0] a);
    logic [7:0] r;
    r = a[7:0] * 8'd7;
    r = r ^ a[15:8] ^ 8'h3C;
    return r;
  endfunction

  // VRAM model with one-clock read latency; preloaded while reset is held.
  always @(posedge clock) begin
    if (reset) begin
      vram_mem[0]  <= 8'h55;
      vram_mem[1]  <= 8'h66;
      vram_rd_data <= 8'h00;
    end else begin
      if (vram_we) vram_mem[vram_addr] <= vram_wr_data;
      if (vram_re) vram_rd_data <= vram_mem[vram_addr];
    end
  end

  // OAM model: synchronous write, combinational read.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < (1 << OAM_AW); i++) oam_mem[i] <= 8'h00;
    end else if (oam_we) begin
      oam_mem[oam_addr] <= oam_wr_data;
    end
  end
  assign oam_rd_data = oam_mem[oam_addr];

  // CPU bus model for DMA reads; data is held until the next read.
  always @(posedge clock) begin
    if (reset)          dma_rd_data <= 8'h00;
    else if (dma_rd_en) dma_rd_data <= cpu_byte(dma_rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write-port monitor, sampled mid-cycle away from the active edge.
  always @(negedge clock) begin
    if (vram_we) begin
      check("vram_we_expected", 32'(vram_exp_q.size() != 0), 32'd1);
      if (vram_exp_q.size() != 0) check("vram_write", {vram_addr, vram_wr_data}, vram_exp_q.pop_front());
    end
    if (oam_we) begin
      check("oam_we_expected", 32'(oam_exp_q.size() != 0), 32'd1);
      if (oam_exp_q.size() != 0) check("oam_write", {oam_addr, oam_wr_data}, oam_exp_q.pop_front());
      oam_wr_seen <= oam_wr_seen + 1;
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic cpu_access(input reg_t sel, input logic rw, input logic [7:0] d);
    reg_sel = sel; reg_rw = rw; reg_data_wr = d; reg_en = 1'b1;
    @(posedge clock); #1;
    reg_en = 1'b0;
  endtask

  task automatic cpu_write(input reg_t sel, input logic [7:0] d);
    cpu_access(sel, 1'b1, d);
  endtask

  task automatic cpu_read(input reg_t sel, input logic [7:0] exp, input string tag);
    rd_exp_q.push_back(exp);
    cpu_access(sel, 1'b0, 8'h00);
    check(tag, reg_data_rd, rd_exp_q.pop_front());
  endtask

  task automatic vram_write(input logic [7:0] d, input logic [VRAM_AW-1:0] exp_addr);
    vram_exp_q.push_back({exp_addr, d});
    cpu_write(REG_PPUDATA, d);
  endtask

  task automatic pulse_events(input logic vs, input logic vc, input logic s0, input logic ov);
    vblank_set = vs; vblank_clr = vc; sprite0_set = s0; ovf_set = ov;
    @(posedge clock); #1;
    vblank_set = 1'b0; vblank_clr = 1'b0; sprite0_set = 1'b0; ovf_set = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no summary after 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act_cycles;
    int base;
    reset = 1'b1; clock_en = 1'b1;
    reg_sel = REG_PPUCTRL; reg_en = 1'b0; reg_rw = 1'b0; reg_data_wr = 8'h00;
    vblank_set = 1'b0; vblank_clr = 1'b0; sprite0_set = 1'b0; ovf_set = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_reg_data_rd", reg_data_rd, 8'h00);
    check("rst_nmi", nmi, 1'b0);
    check("rst_dma_active", dma_active, 1'b0);
    check("rst_vram_addr", vram_addr, 14'h0000);
    check("rst_oam_addr", oam_addr, 8'h00);
    check("rst_ppuctrl", ppuctrl, 8'h00);
    check("rst_scroll_x", scroll_x, 8'h00);
    reset = 1'b0;

    // PPUDATA writes with +1 increment
    cpu_write(REG_PPUCTRL, 8'h00);
    cpu_write(REG_PPUADDR, 8'h21);
    cpu_write(REG_PPUADDR, 8'h08);
    check("ppuaddr_load", vram_addr, 14'h2108);
    vram_write(8'hAB, 14'h2108);
    vram_write(8'hAB, 14'h2109);
    check("vram_addr_inc1", vram_addr, 14'h210A);

    // +32 increment wrapping past the top of VRAM; bits 7:6 of the high byte dropped
    cpu_write(REG_PPUCTRL, 8'h04);
    cpu_write(REG_PPUADDR, 8'hFF);
    cpu_write(REG_PPUADDR, 8'hF0);
    check("ppuaddr_hi_mask", vram_addr, 14'h3FF0);
    vram_write(8'hCD, 14'h3FF0);
    check("vram_addr_inc32_wrap", vram_addr, 14'h0010);

    // Buffered PPUDATA reads
    cpu_write(REG_PPUCTRL, 8'h00);
    cpu_write(REG_PPUADDR, 8'h00);
    cpu_write(REG_PPUADDR, 8'h00);
    cpu_read(REG_PPUDATA, 8'h00, "ppudata_rd0_old_buffer");
    cpu_read(REG_PPUDATA, 8'h55, "ppudata_rd1");
    cpu_read(REG_PPUDATA, 8'h66, "ppudata_rd2");
    check("vram_addr_after_reads", vram_addr, 14'h0003);

    // Status read resets the write toggle
    cpu_write(REG_PPUADDR, 8'h12);
    cpu_read(REG_PPUSTATUS, 8'h12, "status_io_bits");
    cpu_write(REG_PPUSCROLL, 8'h12);
    cpu_write(REG_PPUSCROLL, 8'h34);
    check("scroll_x", scroll_x, 8'h12);
    check("scroll_y", scroll_y, 8'h34);

    // Write-only reads return the io latch; clock_en qualifies accesses
    cpu_read(REG_PPUMASK, 8'h34, "wo_read_io_latch");
    clock_en = 1'b0;
    cpu_write(REG_PPUMASK, 8'h99);
    clock_en = 1'b1;
    check("mask_ignored_no_ce", ppumask, 8'h00);
    cpu_read(REG_OAMDMA, 8'h34, "io_latch_no_ce");
    cpu_write(REG_PPUMASK, 8'h1E);
    check("mask_written", ppumask, 8'h1E);

    // Vblank / NMI behaviour
    pulse_events(1'b1, 1'b0, 1'b0, 1'b0);
    check("nmi_masked", nmi, 1'b0);
    cpu_write(REG_PPUCTRL, 8'h80);
    check("nmi_on_ctrl_enable", nmi, 1'b1);
    cpu_read(REG_PPUSTATUS, 8'h80, "status_vblank");
    check("nmi_cleared_by_read", nmi, 1'b0);
    vblank_set = 1'b1;
    cpu_read(REG_PPUSTATUS, 8'h00, "status_coincident_set");
    vblank_set = 1'b0;
    check("nmi_suppressed", nmi, 1'b0);
    @(posedge clock); #1;
    check("nmi_still_suppressed", nmi, 1'b0);
    pulse_events(1'b0, 1'b0, 1'b1, 1'b1);
    cpu_read(REG_PPUSTATUS, 8'h60, "status_s0_ovf");
    pulse_events(1'b1, 1'b1, 1'b0, 1'b0);
    check("nmi_clr_dominates", nmi, 1'b0);
    cpu_read(REG_PPUSTATUS, 8'h00, "status_after_clr");

    // CPU OAM accesses
    cpu_write(REG_OAMADDR, 8'h10);
    oam_exp_q.push_back({8'h10, 8'h77});
    cpu_write(REG_OAMDATA, 8'h77);
    check("oam_addr_inc", oam_addr, 8'h11);
    cpu_write(REG_OAMADDR, 8'hFF);
    oam_exp_q.push_back({8'hFF, 8'h88});
    cpu_write(REG_OAMDATA, 8'h88);
    check("oam_addr_wrap", oam_addr, 8'h00);
    cpu_write(REG_OAMADDR, 8'h10);
    cpu_read(REG_OAMDATA, 8'h77, "oamdata_read");
    check("oam_addr_no_inc_on_read", oam_addr, 8'h10);

    // Full OAMDMA from page 2 starting at OAM 0x10, with an ignored write mid-transfer
    for (int i = 0; i < DMA_LEN; i++) begin
      logic [7:0] a;
      a = 8'(8'h10 + i);
      oam_exp_q.push_back({a, cpu_byte(16'h0200 + 16'(i))});
    end
    cpu_write(REG_OAMDMA, 8'h02);
    act_cycles = 0;
    for (int k = 0; k < 700; k++) begin
      if (!dma_active) break;
      act_cycles++;
      if (k == 5) begin
        reg_sel = REG_PPUCTRL; reg_rw = 1'b1; reg_data_wr = 8'hFF; reg_en = 1'b1;
      end
      @(posedge clock); #1;
      reg_en = 1'b0;
    end
    check("dma_active_cycles", act_cycles, 513);
    check("dma_oam_q_drained", oam_exp_q.size(), 0);
    check("dma_oam_addr_restored", oam_addr, 8'h10);
    check("dma_ctrl_untouched", ppuctrl, 8'h80);
    cpu_read(REG_PPUCTRL, 8'h02, "dma_io_latch_untouched");

    // Second DMA from page 3 starting at 0xF0, reset after 100 bytes
    cpu_write(REG_OAMADDR, 8'hF0);
    for (int i = 0; i < 100; i++) begin
      logic [7:0] a;
      a = 8'(8'hF0 + i);
      oam_exp_q.push_back({a, cpu_byte(16'h0300 + 16'(i))});
    end
    base = oam_wr_seen;
    cpu_write(REG_OAMDMA, 8'h03);
    for (int k = 0; k < 400; k++) begin
      if (oam_wr_seen - base >= 100) break;
      @(posedge clock); #1;
    end
    check("dma2_writes_before_reset", oam_wr_seen - base, 100);
    reset = 1'b1;
    #1;
    check("dma_active_in_reset_cycle", dma_active, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("dma_active_after_reset", dma_active, 1'b0);
    check("oam_addr_after_reset", oam_addr, 8'h00);
    check("ppuctrl_after_reset", ppuctrl, 8'h00);
    repeat (20) @(posedge clock);
    #1;
    check("dma2_no_writes_after_reset", oam_wr_seen - base, 100);
    check("dma_active_stays_idle", dma_active, 1'b0);
    check("oam_q_drained", oam_exp_q.size(), 0);
    check("vram_q_drained", vram_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
